// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Drives the open-drain PS2_CLK/PS2_DAT lines to send one command byte to the
// keyboard, collects the device acknowledge and reports the outcome with a
// single-cycle tx_done pulse plus a 2-bit status code.
//
// Handshake: tx_start is a level sampled every cycle; it is accepted only in
// IDLE when tx_done is low, at which point tx_data is captured and tx_busy
// rises on the same edge as ps2_clk_oe. tx_busy falls on the edge that raises
// tx_done, and tx_status holds its value from tx_done until the next accepted
// start.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 50,
  parameter int START_TIMEOUT  = 750000,
  parameter int BIT_TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [1:0] tx_status,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic [2:0] dbg_state
);

  // Timer must hold the largest limit; it saturates instead of wrapping.
  localparam int MAX_A   = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int MAX_B   = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
  localparam int MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW      = $clog2(MAX_ALL + 1);

  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] REQ_LAST = TW'(REQ_CYCLES - 1);
  localparam logic [TW-1:0] ST_LAST  = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] BT_LAST  = TW'(BIT_TIMEOUT - 1);

  localparam logic [1:0] ST_START_TO = 2'b01;
  localparam logic [1:0] ST_BIT_TO   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INHIBIT    = 3'd1,
    S_REQ        = 3'd2,
    S_WAIT_FIRST = 3'd3,
    S_SHIFT      = 3'd4,
    S_ACK        = 3'd5,
    S_WAIT_IDLE  = 3'd6
  } state_t;

  // Synchronizers and edge detection
  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic dat_s1_q, dat_s2_q;
  logic fall_q;

  // Transfer state
  state_t        state_q,   state_d;
  logic [TW-1:0] timer_q,   timer_d;
  logic [7:0]    data_q,    data_d;
  logic          parity_q,  parity_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic          nack_q,    nack_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic [1:0]    status_q,  status_d;
  logic          clk_oe_q,  clk_oe_d;
  logic          dat_oe_q,  dat_oe_d;

  logic          fail;
  logic [1:0]    fail_code;
  logic [3:0]    nxt_idx;

  // Two-flop synchronizers on both pads; third clock flop and a registered
  // falling-edge strobe. Lines idle high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      fall_q   <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk_in;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= ps2_dat_in;
      dat_s2_q <= dat_s1_q;
      fall_q   <= clk_s3_q & ~clk_s2_q;
    end
  end

  // State and registered outputs; reset releases both lines asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
      nack_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= 2'b00;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      bit_idx_q <= bit_idx_d;
      nack_q    <= nack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      status_q  <= status_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
    end
  end

  // Next-state and next-output logic for the transfer sequence.
  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;
    data_d    = data_q;
    parity_d  = parity_q;
    bit_idx_d = bit_idx_q;
    nack_d    = nack_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    status_d  = status_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    fail      = 1'b0;
    fail_code = 2'b00;
    nxt_idx   = bit_idx_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        timer_d  = '0;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        // A start coinciding with the completion pulse is dropped.
        if (tx_start && !done_q) begin
          data_d   = tx_data;
          parity_d = ~^tx_data;
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (timer_q == INH_LAST) begin
          dat_oe_d = 1'b1;
          timer_d  = '0;
          state_d  = S_REQ;
        end
      end

      S_REQ: begin
        if (timer_q == REQ_LAST) begin
          // Release the clock; data stays low as the start bit.
          clk_oe_d  = 1'b0;
          bit_idx_d = '0;
          timer_d   = '0;
          state_d   = S_WAIT_FIRST;
        end
      end

      S_WAIT_FIRST: begin
        if (fall_q) begin
          dat_oe_d  = ~data_q[0];
          bit_idx_d = '0;
          timer_d   = '0;
          state_d   = S_SHIFT;
        end else if (timer_q == ST_LAST) begin
          fail      = 1'b1;
          fail_code = ST_START_TO;
        end
      end

      S_SHIFT: begin
        if (fall_q) begin
          timer_d = '0;
          if (bit_idx_q < 4'd7) begin
            bit_idx_d = nxt_idx;
            dat_oe_d  = ~data_q[nxt_idx[2:0]];
          end else if (bit_idx_q == 4'd7) begin
            bit_idx_d = 4'd8;
            dat_oe_d  = ~parity_q;
          end else begin
            // Parity has been taken: release data as the stop bit.
            dat_oe_d = 1'b0;
            state_d  = S_ACK;
          end
        end else if (timer_q == BT_LAST) begin
          fail      = 1'b1;
          fail_code = ST_BIT_TO;
        end
      end

      S_ACK: begin
        if (fall_q) begin
          nack_d  = dat_s2_q;
          timer_d = '0;
          state_d = S_WAIT_IDLE;
        end else if (timer_q == BT_LAST) begin
          fail      = 1'b1;
          fail_code = ST_BIT_TO;
        end
      end

      S_WAIT_IDLE: begin
        if (clk_s2_q && dat_s2_q) begin
          done_d   = 1'b1;
          status_d = {nack_q, nack_q};
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else if (timer_q == BT_LAST) begin
          fail      = 1'b1;
          fail_code = ST_BIT_TO;
        end
      end

      default: begin
        state_d  = S_IDLE;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase

    // Any timeout: free the bus and report; the controller decides on retry.
    if (fail) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      status_d = fail_code;
      timer_d  = '0;
      state_d  = S_IDLE;
    end
  end

  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_status  = status_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int REQ  = 4;
  localparam int STO  = 1000;
  localparam int BTO  = 300;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done;
  logic [1:0] tx_status;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic [2:0] dbg_state;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  int         checks = 0;
  int         errors = 0;
  int         done_count = 0;
  logic [1:0] st_at_done = 2'b00;
  logic       busy_at_done = 1'b0;

  // Open-drain wired lines with pull-ups.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (REQ),
    .START_TIMEOUT (STO),
    .BIT_TIMEOUT   (BTO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_status (tx_status),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Completion monitor
  always @(negedge clk) begin
    if (tx_done) begin
      done_count   <= done_count + 1;
      st_at_done   <= tx_status;
      busy_at_done <= tx_busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Device side of one frame. Clocks at a 2*HALF period, samples data just
  // before each rising edge. stall_at < 10 stops clocking before that clock
  // (hold_low leaves the clock pulled low); otherwise the ACK clock follows.
  task automatic dev_frame(input int stall_at, input bit hold_low, input bit nack,
                           input bit poke, input logic [7:0] poke_data,
                           input bit chk_lat, output logic [9:0] got);
    int n;
    int lat;
    got = '0;
    n = 0;
    while (!(ps2_clk_in && !ps2_dat_in) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      check("wait_release", 0, 1);
      return;
    end
    repeat (10) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i == stall_at) begin
        if (hold_low) begin
          dev_clk_low = 1'b1;
          repeat (8) @(negedge clk);
        end
        return;
      end
      dev_clk_low = 1'b1;
      lat = 0;
      for (int j = 1; j <= HALF; j++) begin
        if (poke && i == 5 && j == 1) begin
          tx_data  = poke_data;
          tx_start = 1'b1;
        end
        @(negedge clk);
        if (poke && i == 5 && j == 1) tx_start = 1'b0;
        if (chk_lat && i == 0 && lat == 0 && !ps2_dat_oe) lat = j;
      end
      if (chk_lat && i == 0) check("edge_to_data_latency", lat, 4);
      got[i] = ps2_dat_in;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    // Acknowledge clock
    dev_dat_low = !nack;
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base);
    int n;
    n = 0;
    while (done_count == base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic [9:0] exp_bits,
                           input bit nack, input int stall_at, input bit poke,
                           input logic [7:0] poke_data, input bit chk,
                           input logic [1:0] exp_st);
    int base;
    int n;
    logic [9:0] got;
    base = done_count;
    start_tx(d);
    if (chk) begin
      check({tag, "_start_clk_oe"}, ps2_clk_oe, 1);
      check({tag, "_start_busy"}, tx_busy, 1);
      n = 0;
      while (ps2_clk_oe && !ps2_dat_oe && n < 100) begin
        n++;
        @(negedge clk);
      end
      check({tag, "_inhibit_cycles"}, n, INH);
      n = 0;
      while (ps2_clk_oe && ps2_dat_oe && n < 100) begin
        n++;
        @(negedge clk);
      end
      check({tag, "_req_cycles"}, n, REQ);
      check({tag, "_start_bit_dat_oe"}, ps2_dat_oe, 1);
    end
    dev_frame(stall_at, 1'b0, nack, poke, poke_data, chk, got);
    wait_done(tag, base);
    if (stall_at >= 10) begin
      check({tag, "_bits"}, got, exp_bits);
      check({tag, "_parity"}, got[8], exp_bits[8]);
    end
    check({tag, "_status"}, st_at_done, exp_st);
    check({tag, "_busy_at_done"}, busy_at_done, 0);
    check({tag, "_oe"}, {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    repeat (60) @(negedge clk);
    check({tag, "_done_count"}, done_count - base, 1);
    check({tag, "_status_hold"}, tx_status, exp_st);
  endtask

  initial begin
    int base;
    int n;
    logic [9:0] got;

    // Reset
    repeat (4) @(negedge clk);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_status", tx_status, 2'b00);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_dat_oe", ps2_dat_oe, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Frames: expected bits are {stop, parity, data[7:0]}
    run_frame("ed",   8'hED, 10'h3ED, 1'b0, 99, 1'b0, 8'h00, 1'b1, 2'b00);
    run_frame("x00",  8'h00, 10'h300, 1'b0, 99, 1'b0, 8'h00, 1'b0, 2'b00);
    run_frame("xff",  8'hFF, 10'h3FF, 1'b0, 99, 1'b0, 8'h00, 1'b0, 2'b00);
    run_frame("x01",  8'h01, 10'h201, 1'b0, 99, 1'b0, 8'h00, 1'b0, 2'b00);
    run_frame("nack", 8'h5A, 10'h35A, 1'b1, 99, 1'b0, 8'h00, 1'b0, 2'b11);

    // No device: start timeout measured from clock release
    base = done_count;
    start_tx(8'h12);
    n = 0;
    while (ps2_clk_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!tx_done && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check("sto_cycles", n, STO);
    check("sto_status", tx_status, 2'b01);
    check("sto_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("sto_busy", tx_busy, 0);
    repeat (20) @(negedge clk);
    check("sto_done_count", done_count - base, 1);

    // Device stalls after bit 3
    run_frame("stall", 8'h3C, 10'h000, 1'b0, 4, 1'b0, 8'h00, 1'b0, 2'b10);

    // Reset during bit 4, then a clean retry
    base = done_count;
    start_tx(8'h00);
    dev_frame(4, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, got);
    check("pre_rst_dat_oe", ps2_dat_oe, 1);
    check("pre_rst_busy", tx_busy, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_clk_oe", ps2_clk_oe, 0);
    check("rst_async_dat_oe", ps2_dat_oe, 0);
    check("rst_async_busy", tx_busy, 0);
    @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_no_done", done_count - base, 0);
    run_frame("retry_f4", 8'hF4, 10'h2F4, 1'b0, 99, 1'b0, 8'h00, 1'b0, 2'b00);

    // Start while busy carries a different byte; original must go out once
    run_frame("busy_poke", 8'hA5, 10'h3A5, 1'b0, 99, 1'b1, 8'h5B, 1'b0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
